// File: rtl/planificador_conversion_bcd_pkg.sv
// paquete_calculadora: definitions shared by the calculator's BCD conversion
// scheduler.
//   ANCHO_BCD_DEF / ANCHO_BIN_DEF : default operand and result widths
//   estado_t                      : scheduler FSM state encoding
//   id_sol_t                      : requester identifier (A or B)
package paquete_calculadora;

    localparam int ANCHO_BCD_DEF = 20;   // 5 BCD digits
    localparam int ANCHO_BIN_DEF = 33;   // binary result

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        ARRANQUE = 2'd1,
        ESPERA   = 2'd2,
        ENTREGA  = 2'd3
    } estado_t;

    typedef enum logic {
        SOL_A = 1'b0,
        SOL_B = 1'b1
    } id_sol_t;

endpackage

// File: rtl/planificador_conversion_bcd_if.sv
// Bus between the two operand requesters, the shared BCD-to-binary
// converter and the scheduler.
//   slave  : scheduler side (receives requests and converter status)
//   master : requester/converter side
//   sol_x/bcd_x        request level and operand from requester x
//   ack_x              accept pulse, listo_x result pulse, resultado_x result
//   conv_inicio/bcd    start pulse and operand sent to the converter
//   conv_resultado/terminado  converter result and done level
//   ocupado/error_tiempo      status flags
interface planificador_conversion_bcd_if
    import paquete_calculadora::*;
#(
    parameter int ANCHO_BCD = ANCHO_BCD_DEF,
    parameter int ANCHO_BIN = ANCHO_BIN_DEF
) ();
    logic                 sol_a, sol_b;
    logic [ANCHO_BCD-1:0] bcd_a, bcd_b;
    logic                 ack_a, ack_b;
    logic                 listo_a, listo_b;
    logic [ANCHO_BIN-1:0] resultado_a, resultado_b;
    logic                 conv_inicio;
    logic [ANCHO_BCD-1:0] conv_bcd;
    logic [ANCHO_BIN-1:0] conv_resultado;
    logic                 conv_terminado;
    logic                 ocupado;
    logic                 error_tiempo;

    modport slave (
        input  sol_a, sol_b, bcd_a, bcd_b, conv_resultado, conv_terminado,
        output ack_a, ack_b, listo_a, listo_b, resultado_a, resultado_b,
               conv_inicio, conv_bcd, ocupado, error_tiempo
    );

    modport master (
        output sol_a, sol_b, bcd_a, bcd_b, conv_resultado, conv_terminado,
        input  ack_a, ack_b, listo_a, listo_b, resultado_a, resultado_b,
               conv_inicio, conv_bcd, ocupado, error_tiempo
    );
endinterface

// File: rtl/planificador_conversion_bcd_detector_flanco.sv
// detector_flanco: rising-edge detector against a registered copy of the input.
//   reloj, reset (async, active low), entrada: level to watch
//   flanco: high while entrada=1 and its value at the previous edge was 0
module detector_flanco (
    input  logic reloj,
    input  logic reset,
    input  logic entrada,
    output logic flanco
);
    logic previo_q;

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) previo_q <= 1'b0;
        else        previo_q <= entrada;
    end

    assign flanco = entrada & ~previo_q;
endmodule

// File: rtl/planificador_conversion_bcd.sv
// planificador_conversion_bcd: round-robin scheduler that shares one
// BCD-to-binary converter between requesters A and B, with a watchdog on
// converter completion.
//   reloj : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : request/response/converter signals (slave modport)
module planificador_conversion_bcd
    import paquete_calculadora::*;
#(
    parameter int ANCHO_BCD     = ANCHO_BCD_DEF,
    parameter int ANCHO_BIN     = ANCHO_BIN_DEF,
    parameter int LIMITE_ESPERA = 64
) (
    input  logic                          reloj,
    input  logic                          reset,
    planificador_conversion_bcd_if.slave  bus
);
    localparam int ANCHO_CNT = $clog2(LIMITE_ESPERA);
    localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(LIMITE_ESPERA - 1);

    estado_t              estado_q, estado_d;
    logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
    id_sol_t              ultimo_q, ultimo_d;       // winner of the last accept
    logic                 hay_ultimo_q, hay_ultimo_d;
    logic [ANCHO_BCD-1:0] bcd_q, bcd_d;
    logic [ANCHO_BIN-1:0] res_a_q, res_a_d, res_b_q, res_b_d;
    logic                 ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic                 listo_a_q, listo_a_d, listo_b_q, listo_b_d;
    logic                 inicio_q, inicio_d;
    logic                 ocupado_q, ocupado_d;
    logic                 error_q, error_d;
    logic                 flanco_fin;
    logic                 gana_b;

    // A level left high by an earlier conversion produces no edge here,
    // so it can never complete a new request.
    detector_flanco u_flanco (
        .reloj   (reloj),
        .reset   (reset),
        .entrada (bus.conv_terminado),
        .flanco  (flanco_fin)
    );

    // B wins when alone, or when both ask and A was the last one served.
    assign gana_b = bus.sol_b &&
                    (!bus.sol_a || (hay_ultimo_q && ultimo_q == SOL_A));

    always_comb begin
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        ultimo_d     = ultimo_q;
        hay_ultimo_d = hay_ultimo_q;
        bcd_d        = bcd_q;
        res_a_d      = res_a_q;
        res_b_d      = res_b_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        listo_a_d    = 1'b0;
        listo_b_d    = 1'b0;
        inicio_d     = 1'b0;
        error_d      = error_q;
        case (estado_q)
            REPOSO: begin
                if (bus.sol_a || bus.sol_b) begin
                    ultimo_d     = gana_b ? SOL_B : SOL_A;
                    hay_ultimo_d = 1'b1;
                    bcd_d        = gana_b ? bus.bcd_b : bus.bcd_a;
                    ack_a_d      = !gana_b;
                    ack_b_d      = gana_b;
                    error_d      = 1'b0;
                    cnt_d        = '0;
                    estado_d     = ARRANQUE;
                end
            end
            ARRANQUE: begin
                inicio_d = 1'b1;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (flanco_fin) begin
                    if (ultimo_q == SOL_A) begin
                        res_a_d   = bus.conv_resultado;
                        listo_a_d = 1'b1;
                    end else begin
                        res_b_d   = bus.conv_resultado;
                        listo_b_d = 1'b1;
                    end
                    estado_d = ENTREGA;
                end else if (cnt_q == CNT_MAX) begin
                    error_d  = 1'b1;
                    estado_d = REPOSO;
                end else begin
                    cnt_d = cnt_q + ANCHO_CNT'(1);
                end
            end
            ENTREGA: estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
        ocupado_d = (estado_d != REPOSO);
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            estado_q     <= REPOSO;
            cnt_q        <= '0;
            ultimo_q     <= SOL_A;
            hay_ultimo_q <= 1'b0;
            bcd_q        <= '0;
            res_a_q      <= '0;
            res_b_q      <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            listo_a_q    <= 1'b0;
            listo_b_q    <= 1'b0;
            inicio_q     <= 1'b0;
            ocupado_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            ultimo_q     <= ultimo_d;
            hay_ultimo_q <= hay_ultimo_d;
            bcd_q        <= bcd_d;
            res_a_q      <= res_a_d;
            res_b_q      <= res_b_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            listo_a_q    <= listo_a_d;
            listo_b_q    <= listo_b_d;
            inicio_q     <= inicio_d;
            ocupado_q    <= ocupado_d;
            error_q      <= error_d;
        end
    end

    assign bus.ack_a        = ack_a_q;
    assign bus.ack_b        = ack_b_q;
    assign bus.listo_a      = listo_a_q;
    assign bus.listo_b      = listo_b_q;
    assign bus.resultado_a  = res_a_q;
    assign bus.resultado_b  = res_b_q;
    assign bus.conv_inicio  = inicio_q;
    assign bus.conv_bcd     = bcd_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.error_tiempo = error_q;
endmodule

// File: tb/tb_planificador_conversion_bcd.sv
// Directed bench for planificador_conversion_bcd. The converter is played
// by the stimulus itself: it raises/lowers conv_terminado and supplies the
// hand-computed binary value at chosen cycles.
module tb_planificador_conversion_bcd;
    logic reloj = 1'b0;
    logic reset = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    int   n_listo_a  = 0;
    int   n_listo_b  = 0;
    int   la, lb;

    planificador_conversion_bcd_if bus ();

    planificador_conversion_bcd dut (
        .reloj (reloj),
        .reset (reset),
        .bus   (bus)
    );

    always #5 reloj = ~reloj;

    // Count listo pulses to prove absence of early/extra deliveries.
    always @(negedge reloj) begin
        if (bus.listo_a) n_listo_a++;
        if (bus.listo_b) n_listo_b++;
    end

    task automatic ciclo();
        @(posedge reloj);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.sol_a = 0; bus.sol_b = 0;
        bus.bcd_a = '0; bus.bcd_b = '0;
        bus.conv_resultado = '0; bus.conv_terminado = 0;

        // Reset state
        #3;
        chk("rst_ack_a",   64'(bus.ack_a), 64'd0);
        chk("rst_ocupado", 64'(bus.ocupado), 64'd0);
        chk("rst_res_a",   64'(bus.resultado_a), 64'd0);
        chk("rst_inicio",  64'(bus.conv_inicio), 64'd0);
        chk("rst_error",   64'(bus.error_tiempo), 64'd0);
        repeat (2) ciclo();
        reset = 1;

        // Simultaneous requests right after reset: A first, then B
        bus.bcd_a = 20'h00012; bus.bcd_b = 20'h99999;
        bus.sol_a = 1; bus.sol_b = 1;
        ciclo();
        chk("sim_ack_a",    64'(bus.ack_a), 64'd1);
        chk("sim_ack_b",    64'(bus.ack_b), 64'd0);
        chk("sim_conv_bcd", 64'(bus.conv_bcd), 64'h00012);
        chk("sim_ocupado",  64'(bus.ocupado), 64'd1);
        bus.sol_a = 0;
        ciclo();
        chk("sim_inicio_on", 64'(bus.conv_inicio), 64'd1);
        chk("sim_ack_a_off", 64'(bus.ack_a), 64'd0);
        ciclo();
        chk("sim_inicio_off", 64'(bus.conv_inicio), 64'd0);
        repeat (3) ciclo();
        bus.conv_resultado = 33'd12; bus.conv_terminado = 1;
        ciclo();
        chk("sim_listo_a", 64'(bus.listo_a), 64'd1);
        chk("sim_res_a",   64'(bus.resultado_a), 64'd12);
        chk("sim_listo_b", 64'(bus.listo_b), 64'd0);
        bus.conv_terminado = 0;
        ciclo();
        chk("sim_listo_a_off", 64'(bus.listo_a), 64'd0);
        chk("sim_reposo",      64'(bus.ocupado), 64'd0);
        chk("sim_b_not_yet",   64'(bus.ack_b), 64'd0);
        ciclo();
        chk("sim_ack_b2",    64'(bus.ack_b), 64'd1);
        chk("sim_conv_bcd2", 64'(bus.conv_bcd), 64'h99999);
        bus.sol_b = 0;
        repeat (4) ciclo();
        bus.conv_resultado = 33'd99999; bus.conv_terminado = 1;
        ciclo();
        chk("sim_listo_b2", 64'(bus.listo_b), 64'd1);
        chk("sim_res_b",    64'(bus.resultado_b), 64'd99999);
        chk("sim_res_a_kept", 64'(bus.resultado_a), 64'd12);
        bus.conv_terminado = 0;
        ciclo();
        chk("sim_end_ocupado", 64'(bus.ocupado), 64'd0);

        // A alone, converter latency 17
        bus.bcd_a = 20'h35789; bus.sol_a = 1;
        ciclo();
        chk("a_ack", 64'(bus.ack_a), 64'd1);
        bus.sol_a = 0;
        ciclo();
        chk("a_inicio",   64'(bus.conv_inicio), 64'd1);
        chk("a_conv_bcd", 64'(bus.conv_bcd), 64'h35789);
        la = n_listo_a;
        repeat (16) ciclo();
        chk("a_no_early", 64'(n_listo_a), 64'(la));
        bus.conv_resultado = 33'd35789; bus.conv_terminado = 1;
        ciclo();
        chk("a_listo", 64'(bus.listo_a), 64'd1);
        chk("a_res",   64'(bus.resultado_a), 64'd35789);
        ciclo();   // conv_terminado stays high: stale level for the next request
        chk("a_listo_off", 64'(bus.listo_a), 64'd0);
        chk("a_ocupado",   64'(bus.ocupado), 64'd0);

        // Round robin (A served last -> B first) with stale done level;
        // B's operand carries non-decimal digits that must pass untouched.
        bus.bcd_a = 20'h00300; bus.bcd_b = 20'h4A0F9;
        bus.sol_a = 1; bus.sol_b = 1;
        ciclo();
        chk("rr_ack_b",    64'(bus.ack_b), 64'd1);
        chk("rr_ack_a",    64'(bus.ack_a), 64'd0);
        chk("rr_conv_bcd", 64'(bus.conv_bcd), 64'h4A0F9);
        bus.sol_b = 0;
        ciclo();
        lb = n_listo_b;
        repeat (10) ciclo();
        chk("stale_no_listo", 64'(n_listo_b), 64'(lb));
        chk("stale_ocupado",  64'(bus.ocupado), 64'd1);
        bus.conv_terminado = 0;
        ciclo();
        bus.conv_resultado = 33'h1_2345_6789; bus.conv_terminado = 1;
        ciclo();
        chk("stale_listo_b", 64'(bus.listo_b), 64'd1);
        chk("stale_res_b",   64'(bus.resultado_b), 64'h1_2345_6789);
        ciclo();
        chk("stale_reposo",  64'(bus.ocupado), 64'd0);
        bus.conv_terminado = 0;

        // Timeout: A still requesting, converter never finishes
        ciclo();
        chk("to_ack_a", 64'(bus.ack_a), 64'd1);
        bus.sol_a = 0;
        la = n_listo_a;
        ciclo();   // ESPERA entry
        repeat (63) ciclo();
        chk("to_err_early", 64'(bus.error_tiempo), 64'd0);
        chk("to_busy",      64'(bus.ocupado), 64'd1);
        ciclo();
        chk("to_err",     64'(bus.error_tiempo), 64'd1);
        chk("to_ocupado", 64'(bus.ocupado), 64'd0);
        chk("to_listo",   64'(n_listo_a), 64'(la));
        chk("to_res_a",   64'(bus.resultado_a), 64'd35789);
        ciclo();
        chk("to_sticky", 64'(bus.error_tiempo), 64'd1);

        // New request clears the flag in its ack cycle
        bus.bcd_a = 20'h00450; bus.sol_a = 1;
        ciclo();
        chk("clr_ack",   64'(bus.ack_a), 64'd1);
        chk("clr_error", 64'(bus.error_tiempo), 64'd0);
        bus.sol_a = 0;
        repeat (3) ciclo();

        // Reset in ESPERA: outputs clear without a clock edge
        reset = 0;
        #1;
        chk("mr_ocupado",  64'(bus.ocupado), 64'd0);
        chk("mr_conv_bcd", 64'(bus.conv_bcd), 64'd0);
        chk("mr_res_a",    64'(bus.resultado_a), 64'd0);
        chk("mr_res_b",    64'(bus.resultado_b), 64'd0);
        ciclo();
        reset = 1;
        bus.bcd_a = 20'h00007; bus.sol_a = 1;
        ciclo();
        chk("mr_ack_a", 64'(bus.ack_a), 64'd1);
        bus.sol_a = 0;
        repeat (2) ciclo();
        bus.conv_resultado = 33'd7; bus.conv_terminado = 1;
        ciclo();
        chk("mr_listo_a", 64'(bus.listo_a), 64'd1);
        chk("mr_res_a7",  64'(bus.resultado_a), 64'd7);
        ciclo();
        chk("mr_end", 64'(bus.ocupado), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/planificador_conversion_bcd.md
# planificador_conversion_bcd

Shares the single BCD-to-binary converter (`convertidor_bcd_binario`) between the calculator's two operand requesters, A and B. The block accepts one request at a time using round-robin arbitration. It latches the requester's BCD word, pulses the converter start, and waits for a fresh completion edge. It then returns the 33-bit result to the winning requester with a one-cycle valid pulse. A watchdog flags a converter that never finishes.

## Interface
- `ANCHO_BCD`, 20: width of the BCD operand (5 digits).
- `ANCHO_BIN`, 33: width of the binary result.
- `LIMITE_ESPERA`, 64: maximum number of ESPERA cycles before a timeout.
- `reloj`  in  1  the single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sol_a` / `sol_b`  in  1  request level from A / B; held high with stable `bcd_x` until `ack_x` is seen.
- `bcd_a` / `bcd_b`  in  ANCHO_BCD  operand from A / B.
- `ack_a` / `ack_b`  out  1  one-cycle pulse: request accepted and `bcd_x` latched.
- `listo_a` / `listo_b`  out  1  one-cycle pulse: `resultado_x` was updated.
- `resultado_a` / `resultado_b`  out  ANCHO_BIN  last result for that requester, held until that requester's next result.
- `conv_inicio`  out  1  start pulse to the converter.
- `conv_bcd`  out  ANCHO_BCD  latched operand driven to the converter.
- `conv_resultado`  in  ANCHO_BIN  converter result.
- `conv_terminado`  in  1  converter done; may be a level that stays high after completion.
- `ocupado`  out  1  high whenever the FSM is not in REPOSO.
- `error_tiempo`  out  1  sticky timeout flag; cleared at the next accept.

## Operation
- FSM states and transitions:
  - REPOSO: wait for a request.
  - ARRANQUE: drive the start pulse.
  - ESPERA: wait for completion or timeout.
  - ENTREGA: one guard cycle after delivery.
- Reset (`reset`=0, asynchronous):
  - Every output and register goes to 0.
  - State goes to REPOSO.
  - Priority pointer goes to A; the last-served record is cleared.
- REPOSO, with `sol_a` or `sol_b` sampled high:
  - If only one request is high, it wins.
  - If both are high, the one not served last wins; after reset, A wins.
  - Load `conv_bcd` <= `bcd_x`.
  - Set `ack_x` <= 1 and remember the winner.
  - Clear `error_tiempo`, clear the counter, and go to ARRANQUE.
- ARRANQUE: `conv_inicio` <= 1 for exactly one cycle, then go to ESPERA. `conv_terminado` is ignored in this state.
- ESPERA:
  - Completion requires a rising edge of `conv_terminado`: current value 1 and registered previous value 0. A level that stays high from an earlier conversion never completes a request.
  - On a rising edge: `resultado_x` <= `conv_resultado`, `listo_x` <= 1, go to ENTREGA.
  - Otherwise the counter increments each cycle.
  - When the counter reaches `LIMITE_ESPERA`-1 with no edge: `error_tiempo` <= 1, go to REPOSO. No `listo_x` pulse; `resultado_x` is unchanged.
- ENTREGA: `listo_x` returns to 0, then go to REPOSO.
- Arithmetic and width rules:
  - No arithmetic on the data; the BCD word passes through untouched, including invalid digits above 9.
  - The counter is $clog2(LIMITE_ESPERA) bits wide and never wraps: it is cleared on each accept.
- A request dropped before it is sampled in REPOSO is simply never served.
- The non-winning requester keeps its request high and is served on the next REPOSO cycle.

## Timing
- All outputs are registered.
- For an accept at edge k:
  - `ack_x` is high during cycle k..k+1.
  - `conv_inicio` is high during cycle k+1..k+2.
  - `ocupado` is high from edge k until the return to REPOSO.
- For a `conv_terminado` rise sampled at edge m:
  - `listo_x` is high during cycle m..m+1, with `resultado_x` already valid.
  - Back in REPOSO at m+1; the earliest next accept is at edge m+2.
- Overhead: a full transaction takes the converter latency plus 4 cycles.
- Timeout: `error_tiempo` rises `LIMITE_ESPERA` cycles after ESPERA entry.
- A requester may drop `sol_x` on the edge after it sees `ack_x`; no double accept is possible, because the FSM has left REPOSO by then.

## Structure
- Shared package `paquete_calculadora` holds:
  - `ANCHO_BCD` and `ANCHO_BIN` defaults.
  - FSM state encodings: REPOSO=0, ARRANQUE=1, ESPERA=2, ENTREGA=3.
  - A requester-ID encoding.
- Sub-module `detector_flanco` provides the registered rising-edge detector for `conv_terminado`. Its reset follows the same asynchronous, active-low rule.

## Test plan
- A alone:
  - Stimulus: `bcd_a`=20'h35789, converter model latency 17 cycles.
  - Response: one `ack_a` pulse; `conv_inicio` one cycle wide with `conv_bcd`=20'h35789; `listo_a` one cycle after the `conv_terminado` rise; `resultado_a`=33'd35789; `ocupado` low afterwards.
- Simultaneous requests right after reset:
  - Stimulus: A=20'h00012, B=20'h99999, both raised together.
  - Response: A is served first (`resultado_a`=12), then B (`resultado_b`=99999); `resultado_a` stays 12 throughout.
- Round-robin alternation:
  - Stimulus: serve A alone, then raise A and B together.
  - Response: B is acked first.
- Stale `conv_terminado`:
  - Stimulus: the model holds `conv_terminado` high after the previous conversion, then lowers and re-raises it 10 cycles into the new request.
  - Response: no `listo` pulse until the re-raise.
- Timeout:
  - Stimulus: `LIMITE_ESPERA`=64, model never asserts `conv_terminado`.
  - Response: `error_tiempo`=1 exactly 64 cycles after ESPERA entry; no `listo_x` pulse; `ocupado`=0.
  - Follow-up: a new request clears `error_tiempo` in its `ack` cycle.
- Reset mid-operation:
  - Stimulus: `reset`=0 during ESPERA.
  - Response: all outputs are 0 immediately, without waiting for a clock edge. After release, A=20'h00007 completes normally with `resultado_a`=7.
